// File: rtl/karatsuba_mult_pipe_pkg.sv
// ---------------------------------------------------------------------------
// karatsuba_mult_pipe_pkg
// Shared constants and width helpers for the pipelined Karatsuba multiplier.
//   split_lo(w)  : low-half width  L = floor(w/2)
//   split_hi(w)  : high-half width H = w - L
//   phi_w/plo_w/pmid_w : widths of the three partial products
//   STAGES       : number of register stages between input and output
// ---------------------------------------------------------------------------
package karatsuba_mult_pipe_pkg;

   localparam int STAGES = 3;

   function automatic int split_lo(input int w);
      return w / 2;
   endfunction

   function automatic int split_hi(input int w);
      return w - (w / 2);
   endfunction

   // Ah*Bh
   function automatic int phi_w(input int w);
      return 2 * split_hi(w);
   endfunction

   // Al*Bl
   function automatic int plo_w(input int w);
      return 2 * split_lo(w);
   endfunction

   // (Ah+Al)*(Bh+Bl), each sum is H+1 bits wide
   function automatic int pmid_w(input int w);
      return 2 * split_hi(w) + 2;
   endfunction

endpackage

// File: rtl/karat_stage_reg.sv
// ---------------------------------------------------------------------------
// karat_stage_reg
// One valid/data pipeline register stage.
//   clk, rst_n : clock, asynchronous active-low reset (clears valid and data)
//   i_clear    : synchronous flush of the valid flag
//   i_load     : stage may take a new entry this cycle (it is empty or its
//                contents are moving on)
//   i_valid    : the entry offered by the upstream stage is real
//   i_data     : payload offered by the upstream stage
//   o_valid    : stage holds a real entry
//   o_data     : held payload, stable while i_load is low
// ---------------------------------------------------------------------------
module karat_stage_reg #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clear,
   input  logic          i_load,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   output logic [DW-1:0] o_data
);

   logic          r_valid;
   logic [DW-1:0] r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         if (i_clear) begin
            r_valid <= 1'b0;
         end else if (i_load) begin
            r_valid <= i_valid;
         end
         // Payload only moves for real entries, so a bubble passing through
         // does not disturb what the stage last held.
         if (i_load && i_valid && !i_clear) begin
            r_data <= i_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/karatsuba_mult_pipe.sv
// ---------------------------------------------------------------------------
// karatsuba_mult_pipe
// Three-stage pipelined one-level Karatsuba multiplier, unsigned or two's
// complement per transaction, with a user tag carried alongside.
//   clk, rst_n   : clock, asynchronous active-low reset
//   Clear_i      : synchronous flush of every in-flight operation
//   In_valid_i   : operand pair valid       In_ready_o : pair accepted
//   Data_A_i/B_i : W-bit operands           Signed_i   : 1 = two's complement
//   Tag_i        : tag returned with the product
//   Out_valid_o  : product valid            Out_ready_i: downstream accepts
//   Data_S_o     : 2W-bit product           Tag_o      : tag of that product
//
// Handshake: a transfer happens on any cycle where valid and ready are both
// high at the rising edge. Ready never depends on the same side's valid, and
// a presented output (valid high) stays unchanged until it is taken.
//
// S1: magnitudes split into halves, half sums, result sign, tag
// S2: P_hi = Ah*Bh, P_lo = Al*Bl, P_mid = (Ah+Al)*(Bh+Bl)
// S3: recombination and sign restore
// ---------------------------------------------------------------------------
module karatsuba_mult_pipe
   import karatsuba_mult_pipe_pkg::*;
#(
   parameter int W     = 24,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Clear_i,
   input  logic             In_valid_i,
   output logic             In_ready_o,
   input  logic [W-1:0]     Data_A_i,
   input  logic [W-1:0]     Data_B_i,
   input  logic             Signed_i,
   input  logic [TAG_W-1:0] Tag_i,
   output logic             Out_valid_o,
   input  logic             Out_ready_i,
   output logic [2*W-1:0]   Data_S_o,
   output logic [TAG_W-1:0] Tag_o
);

   localparam int L      = split_lo(W);
   localparam int H      = split_hi(W);
   localparam int PHI_W  = phi_w(W);
   localparam int PLO_W  = plo_w(W);
   localparam int PMID_W = pmid_w(W);
   localparam int PW     = 2 * W;

   localparam int D1 = 1 + TAG_W + 2 * H + 2 * L + 2 * (H + 1);
   localparam int D2 = 1 + TAG_W + PHI_W + PLO_W + PMID_W;
   localparam int D3 = TAG_W + PW;

   // ------------------------------------------------------------------------
   // Flow control. Index k is stage S(k+1). A stage loads when it is empty or
   // when its contents move on, which lets bubbles collapse.
   // ------------------------------------------------------------------------
   logic [STAGES-1:0] w_vld;
   logic [STAGES-1:0] w_en;
   logic              r_init;

   // In_ready_o stays low through reset and for the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_init <= 1'b0;
      end else begin
         r_init <= 1'b1;
      end
   end

   always_comb begin
      w_en[STAGES-1] = ~w_vld[STAGES-1] | Out_ready_i;
      for (int k = STAGES - 2; k >= 0; k--) begin
         w_en[k] = ~w_vld[k] | w_en[k+1];
      end
   end

   // Clear wins over a simultaneous input, so ready drops during the clear.
   assign In_ready_o  = r_init & ~Clear_i & w_en[0];
   assign Out_valid_o = w_vld[STAGES-1];

   // ------------------------------------------------------------------------
   // S1 input side: magnitudes, halves, half sums, sign
   // ------------------------------------------------------------------------
   logic         w_neg_a;
   logic         w_neg_b;
   logic [W-1:0] w_abs_a;
   logic [W-1:0] w_abs_b;
   logic         w_sign;
   logic [H:0]   w_sa;
   logic [H:0]   w_sb;
   logic [D1-1:0] w_s1_d;

   assign w_neg_a = Signed_i & Data_A_i[W-1];
   assign w_neg_b = Signed_i & Data_B_i[W-1];
   // -2^(W-1) negates to itself, which read unsigned is the right magnitude.
   assign w_abs_a = w_neg_a ? -Data_A_i : Data_A_i;
   assign w_abs_b = w_neg_b ? -Data_B_i : Data_B_i;
   assign w_sign  = Signed_i & (Data_A_i[W-1] ^ Data_B_i[W-1]);
   assign w_sa    = (H+1)'(w_abs_a[W-1:L]) + (H+1)'(w_abs_a[L-1:0]);
   assign w_sb    = (H+1)'(w_abs_b[W-1:L]) + (H+1)'(w_abs_b[L-1:0]);

   assign w_s1_d = {w_sign, Tag_i,
                    w_abs_a[W-1:L], w_abs_a[L-1:0],
                    w_abs_b[W-1:L], w_abs_b[L-1:0],
                    w_sa, w_sb};

   logic          w_s1_v;
   logic [D1-1:0] w_s1_q;

   karat_stage_reg #(.DW(D1)) u_s1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (Clear_i),
      .i_load  (w_en[0]),
      .i_valid (In_valid_i & In_ready_o),
      .i_data  (w_s1_d),
      .o_valid (w_s1_v),
      .o_data  (w_s1_q)
   );

   assign w_vld[0] = w_s1_v;

   // ------------------------------------------------------------------------
   // S2 input side: three partial products
   // ------------------------------------------------------------------------
   logic             w_s1_sign;
   logic [TAG_W-1:0] w_s1_tag;
   logic [H-1:0]     w_s1_ah;
   logic [L-1:0]     w_s1_al;
   logic [H-1:0]     w_s1_bh;
   logic [L-1:0]     w_s1_bl;
   logic [H:0]       w_s1_sa;
   logic [H:0]       w_s1_sb;

   assign {w_s1_sign, w_s1_tag, w_s1_ah, w_s1_al,
           w_s1_bh, w_s1_bl, w_s1_sa, w_s1_sb} = w_s1_q;

   logic [PHI_W-1:0]  w_phi;
   logic [PLO_W-1:0]  w_plo;
   logic [PMID_W-1:0] w_pmid;
   logic [D2-1:0]     w_s2_d;

   assign w_phi  = PHI_W'(w_s1_ah) * PHI_W'(w_s1_bh);
   assign w_plo  = PLO_W'(w_s1_al) * PLO_W'(w_s1_bl);
   assign w_pmid = PMID_W'(w_s1_sa) * PMID_W'(w_s1_sb);
   assign w_s2_d = {w_s1_sign, w_s1_tag, w_phi, w_plo, w_pmid};

   logic          w_s2_v;
   logic [D2-1:0] w_s2_q;

   karat_stage_reg #(.DW(D2)) u_s2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (Clear_i),
      .i_load  (w_en[1]),
      .i_valid (w_s1_v),
      .i_data  (w_s2_d),
      .o_valid (w_s2_v),
      .o_data  (w_s2_q)
   );

   assign w_vld[1] = w_s2_v;

   // ------------------------------------------------------------------------
   // S3 input side: recombination and sign restore
   // ------------------------------------------------------------------------
   logic              w_s2_sign;
   logic [TAG_W-1:0]  w_s2_tag;
   logic [PHI_W-1:0]  w_s2_phi;
   logic [PLO_W-1:0]  w_s2_plo;
   logic [PMID_W-1:0] w_s2_pmid;

   assign {w_s2_sign, w_s2_tag, w_s2_phi, w_s2_plo, w_s2_pmid} = w_s2_q;

   logic [PW-1:0] w_mid;
   logic [PW-1:0] w_mag;
   logic [PW-1:0] w_prod;
   logic [D3-1:0] w_s3_d;

   // The true middle term is non-negative and every term fits in 2W bits, so
   // modulo-2^(2W) arithmetic gives the exact magnitude.
   assign w_mid  = PW'(w_s2_pmid) - PW'(w_s2_phi) - PW'(w_s2_plo);
   assign w_mag  = (PW'(w_s2_phi) << (2 * L)) + (w_mid << L) + PW'(w_s2_plo);
   assign w_prod = w_s2_sign ? -w_mag : w_mag;
   assign w_s3_d = {w_s2_tag, w_prod};

   logic          w_s3_v;
   logic [D3-1:0] w_s3_q;

   karat_stage_reg #(.DW(D3)) u_s3 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (Clear_i),
      .i_load  (w_en[2]),
      .i_valid (w_s2_v),
      .i_data  (w_s3_d),
      .o_valid (w_s3_v),
      .o_data  (w_s3_q)
   );

   assign w_vld[2]          = w_s3_v;
   assign {Tag_o, Data_S_o} = w_s3_q;

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_karatsuba_mult_pipe
// Bench for karatsuba_mult_pipe: a W=8 instance for directed, backpressure,
// clear and reset cases, and a W=7 instance for an odd-split random stream.
// ---------------------------------------------------------------------------
module tb_karatsuba_mult_pipe;
   import karatsuba_mult_pipe_pkg::*;

   localparam int TW = 4;

   int checks = 0;
   int errors = 0;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- W=8 instance ----------------
   logic          clr8 = 0, iv8 = 0, ir8, s8 = 0, ov8, or8 = 1;
   logic [7:0]    a8 = 0, b8 = 0;
   logic [TW-1:0] t8 = 0, to8;
   logic [15:0]   ds8;

   karatsuba_mult_pipe #(.W(8), .TAG_W(TW)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .Clear_i(clr8), .In_valid_i(iv8),
      .In_ready_o(ir8), .Data_A_i(a8), .Data_B_i(b8), .Signed_i(s8),
      .Tag_i(t8), .Out_valid_o(ov8), .Out_ready_i(or8), .Data_S_o(ds8),
      .Tag_o(to8)
   );

   // ---------------- W=7 instance ----------------
   logic          clr7 = 0, iv7 = 0, ir7, s7 = 0, ov7, or7 = 1;
   logic [6:0]    a7 = 0, b7 = 0;
   logic [TW-1:0] t7 = 0, to7;
   logic [13:0]   ds7;

   karatsuba_mult_pipe #(.W(7), .TAG_W(TW)) u_dut7 (
      .clk(clk), .rst_n(rst_n), .Clear_i(clr7), .In_valid_i(iv7),
      .In_ready_o(ir7), .Data_A_i(a7), .Data_B_i(b7), .Signed_i(s7),
      .Tag_i(t7), .Out_valid_o(ov7), .Out_ready_i(or7), .Data_S_o(ds7),
      .Tag_o(to7)
   );

   // ---------------- scoreboards ----------------
   logic [TW+15:0] exp8_q[$];
   logic [TW+13:0] exp7_q[$];

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Reference product, truncated to 2w bits.
   function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a,
                                             input logic [31:0] b, input logic sgn);
      longint va, vb, p;
      va = longint'(a);
      vb = longint'(b);
      if (sgn && a[w-1]) va = va - (longint'(1) << w);
      if (sgn && b[w-1]) vb = vb - (longint'(1) << w);
      p = va * vb;
      return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   always @(negedge clk) begin
      if (rst_n && ov8 && or8) begin
         checks++;
         assert (exp8_q.size() != 0) else begin
            errors++;
            $error("FAIL out8_spurious: observed tag %0h data %0h expected no output", to8, ds8);
         end
         if (exp8_q.size() != 0) check("out8", {to8, ds8}, exp8_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov7 && or7) begin
         checks++;
         assert (exp7_q.size() != 0) else begin
            errors++;
            $error("FAIL out7_spurious: observed tag %0h data %0h expected no output", to7, ds7);
         end
         if (exp7_q.size() != 0) check("out7", {to7, ds7}, exp7_q.pop_front());
      end
   end

   // ---------------- drivers (call at posedge + 1) ----------------
   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                         input logic [TW-1:0] tag, input logic [15:0] exp);
      logic acc;
      int   tries;
      acc = 0; tries = 0;
      iv8 = 1; a8 = a; b8 = b; s8 = sgn; t8 = tag;
      while (!acc && tries < 50) begin
         @(negedge clk); acc = ir8;
         @(posedge clk); #1; tries++;
      end
      check("accept8", 64'(acc), 64'd1);
      if (acc) exp8_q.push_back({tag, exp});
      iv8 = 0;
   endtask

   task automatic drive7(input logic [6:0] a, input logic [6:0] b, input logic sgn,
                         input logic [TW-1:0] tag, input logic [13:0] exp);
      logic acc;
      int   tries;
      acc = 0; tries = 0;
      iv7 = 1; a7 = a; b7 = b; s7 = sgn; t7 = tag;
      while (!acc && tries < 50) begin
         @(negedge clk); acc = ir7;
         @(posedge clk); #1; tries++;
      end
      check("accept7", 64'(acc), 64'd1);
      if (acc) exp7_q.push_back({tag, exp});
      iv7 = 0;
   endtask

   // One op into an empty pipe; Out_valid must rise in the third cycle after.
   task automatic send_timed8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                              input logic [TW-1:0] tag, input logic [15:0] exp);
      drive8(a, b, sgn, tag, exp);
      @(negedge clk); check("lat8_c1", 64'(ov8), 64'd0);
      @(negedge clk); check("lat8_c2", 64'(ov8), 64'd0);
      @(negedge clk); check("lat8_c3", 64'(ov8), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic drain8();
      for (int i = 0; i < 30 && exp8_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check("drain8", 64'(exp8_q.size()), 64'd0);
   endtask

   task automatic drain7();
      for (int i = 0; i < 30 && exp7_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check("drain7", 64'(exp7_q.size()), 64'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: observed no end of test expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

   // ---------------- directed sequence ----------------
   logic [7:0]    bp_a[6], bp_b[6];
   logic          bp_s[6];
   int            idx;
   logic          acc_now;
   logic [7:0]    ra, rb;
   logic          rs;

   initial begin
      // Reset state
      #3;
      check("rst_ov", 64'(ov8), 64'd0);
      check("rst_ds", 64'(ds8), 64'd0);
      check("rst_tag", 64'(to8), 64'd0);
      check("rst_ready", 64'(ir8), 64'd0);
      #19 rst_n = 1;
      #1 check("ready_before_edge", 64'(ir8), 64'd0);
      @(negedge clk); check("ready_after_release", 64'(ir8), 64'd1);
      @(posedge clk); #1;

      // Directed W=8 cases
      send_timed8(8'hFF, 8'hFF, 1'b0, 4'h1, 16'hFE01);
      drive8(8'h00, 8'hAB, 1'b0, 4'h2, 16'h0000);
      drive8(8'h80, 8'h80, 1'b1, 4'h3, 16'h4000);
      drive8(8'h80, 8'h7F, 1'b1, 4'h4, 16'hC080);
      drive8(8'hFF, 8'h01, 1'b1, 4'h5, 16'hFFFF);
      drain8();

      // W=7 odd split: 127*127 then 20 random pairs back to back
      drive7(7'd127, 7'd127, 1'b0, 4'h0, 14'h3F01);
      for (int i = 0; i < 20; i++) begin
         logic [6:0] x, y;
         logic       sg;
         x  = 7'($urandom_range(0, 127));
         y  = 7'($urandom_range(0, 127));
         sg = 1'($urandom_range(0, 1));
         drive7(x, y, sg, TW'(i + 1), 14'(ref_prod(7, 32'(x), 32'(y), sg)));
      end
      drain7();

      // Backpressure: 6 pairs offered with Out_ready low
      for (int i = 0; i < 6; i++) begin
         bp_a[i] = 8'($urandom_range(0, 255));
         bp_b[i] = 8'($urandom_range(0, 255));
         bp_s[i] = 1'($urandom_range(0, 1));
      end
      or8 = 0;
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         iv8 = (idx < 6);
         a8 = bp_a[idx % 6]; b8 = bp_b[idx % 6]; s8 = bp_s[idx % 6]; t8 = TW'(8 + idx);
         @(negedge clk);
         acc_now = ir8 & iv8;
         if (c >= 3) begin
            check("bp_valid_held", 64'(ov8), 64'd1);
            check("bp_data_held", {to8, ds8}, exp8_q[0]);
         end
         @(posedge clk); #1;
         if (acc_now) begin
            exp8_q.push_back({t8, 16'(ref_prod(8, 32'(a8), 32'(b8), s8))});
            idx++;
         end
      end
      iv8 = 0;
      check("bp_accepted", 64'(idx), 64'(STAGES));
      @(negedge clk); check("bp_ready_low", 64'(ir8), 64'd0);
      @(posedge clk); #1;
      or8 = 1;
      while (idx < 6) begin
         drive8(bp_a[idx], bp_b[idx], bp_s[idx], TW'(8 + idx),
                16'(ref_prod(8, 32'(bp_a[idx]), 32'(bp_b[idx]), bp_s[idx])));
         idx++;
      end
      drain8();

      // Clear with three ops in flight and a simultaneous input
      or8 = 0;
      drive8(8'h12, 8'h34, 1'b0, 4'hA, 16'(ref_prod(8, 32'h12, 32'h34, 1'b0)));
      drive8(8'h56, 8'h78, 1'b0, 4'hB, 16'(ref_prod(8, 32'h56, 32'h78, 1'b0)));
      drive8(8'h9A, 8'hBC, 1'b1, 4'hC, 16'(ref_prod(8, 32'h9A, 32'hBC, 1'b1)));
      clr8 = 1; iv8 = 1; a8 = 8'h11; b8 = 8'h22; s8 = 0; t8 = 4'hD;
      @(negedge clk); check("clr_ready_low", 64'(ir8), 64'd0);
      @(posedge clk); #1;
      clr8 = 0; iv8 = 0; or8 = 1;
      exp8_q.delete();
      check("clr_valid_low", 64'(ov8), 64'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); check("clr_no_stale", 64'(ov8), 64'd0);
      end
      @(posedge clk); #1;
      send_timed8(8'h0F, 8'h0E, 1'b0, 4'hE, 16'h00D2);
      drain8();

      // Async reset mid-stream
      drive8(8'h21, 8'h43, 1'b0, 4'h1, 16'(ref_prod(8, 32'h21, 32'h43, 1'b0)));
      drive8(8'hE5, 8'h07, 1'b1, 4'h2, 16'(ref_prod(8, 32'hE5, 32'h07, 1'b1)));
      drive8(8'h3C, 8'hC3, 1'b0, 4'h3, 16'(ref_prod(8, 32'h3C, 32'hC3, 1'b0)));
      @(posedge clk); #3;
      rst_n = 0;
      #1;
      check("arst_ov", 64'(ov8), 64'd0);
      check("arst_ds", 64'(ds8), 64'd0);
      check("arst_ready", 64'(ir8), 64'd0);
      exp8_q.delete();
      @(negedge clk); #2;
      rst_n = 1;
      @(posedge clk); #1;
      check("arst_ready_back", 64'(ir8), 64'd1);
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      send_timed8(ra, rb, rs, 4'h7, 16'(ref_prod(8, 32'(ra), 32'(rb), rs)));
      drain8();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
